// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer controller slice.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    TIME,
    DONE,
    EARLY
  } rc_state_t;

  localparam logic [3:0]  GLYPH_BLANK = 4'hC;
  localparam logic [3:0]  GLYPH_H     = 4'hA;
  localparam logic [3:0]  GLYPH_I     = 4'hB;
  localparam logic [15:0] TIMEOUT_BCD = 16'h1000;
  localparam logic [15:0] EARLY_BCD   = 16'h9999;
  localparam int unsigned MIN_DELAY_S = 2;

  localparam logic [15:0] IDLE_HEX  = {GLYPH_BLANK, GLYPH_BLANK, GLYPH_H, GLYPH_I};
  localparam logic [15:0] BLANK_HEX = {4{GLYPH_BLANK}};

  // Pre-start delay in ms: max(rnd, MIN_DELAY_S) seconds, 2000..15000 fits in 14 bits.
  function automatic logic [13:0] delay_ms_of(input logic [3:0] r);
    logic [3:0] secs;
    secs = (r < 4'(MIN_DELAY_S)) ? 4'(MIN_DELAY_S) : r;
    return 14'(secs) * 14'd1000;
  endfunction

endpackage

// File: rtl/reaction_ctrl_if.sv
// Strobe/data link between the controller and the external BCD ms counter.
interface reaction_ctrl_if;
  logic        cnt_clr;
  logic        cnt_inc;
  logic [15:0] cnt_d;

  modport master (output cnt_clr, output cnt_inc, input cnt_d);
  modport slave  (input cnt_clr, input cnt_inc, output cnt_d);
endinterface

// File: rtl/reaction_ctrl_ms_tick.sv
// Millisecond prescaler: tick lands DIV clocks after each sync_clr, then every DIV clocks.
module ms_tick #(
  parameter int unsigned DIV = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_clr,
  output logic tick
);

  localparam int unsigned W = $clog2(DIV + 1);

  logic [W-1:0] cnt;

  // Counts 1..DIV after the first pass from 0, so the first period after a clear is full length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (sync_clr)       cnt <= '0;
    else if (cnt == W'(DIV)) cnt <= W'(1);
    else                     cnt <= cnt + W'(1);
  end

  assign tick = (cnt == W'(DIV));

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencer: random delay, ms counter strobes, result/best tracking, display select.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_tick,
  input  logic                   stop_tick,
  input  logic                   clear_tick,
  input  logic [3:0]             rnd,
  reaction_ctrl_if.master        cnt,
  output logic [15:0]            hex,
  output logic [3:0]             dp,
  output logic                   led,
  output logic [15:0]            best
);

  localparam int unsigned TICK_DIV = CLK_HZ / 1000;

  rc_state_t   state, state_nxt;
  logic [13:0] delay_ms;
  logic [13:0] delay_cnt;
  logic [15:0] result;
  logic        tick;
  logic        sync_clr;

  ms_tick #(.DIV(TICK_DIV)) u_ms_tick (
    .clk      (clk),
    .rst      (rst),
    .sync_clr (sync_clr),
    .tick     (tick)
  );

  always_comb begin
    state_nxt = state;
    sync_clr  = 1'b0;
    unique case (state)
      IDLE: if (!clear_tick && start_tick) state_nxt = ARM;
      ARM: begin
        sync_clr  = 1'b1;
        state_nxt = clear_tick ? IDLE : WAIT;
      end
      WAIT: begin
        if (clear_tick)     state_nxt = IDLE;
        else if (stop_tick) state_nxt = EARLY;
        // Leave on the tick that brings delay_cnt up to delay_ms.
        else if (tick && (delay_cnt == delay_ms - 14'd1)) begin
          state_nxt = TIME;
          sync_clr  = 1'b1;
        end
      end
      TIME: begin
        if (clear_tick)                                 state_nxt = IDLE;
        else if (stop_tick || cnt.cnt_d == TIMEOUT_BCD) state_nxt = DONE;
      end
      DONE, EARLY: begin
        if (clear_tick)      state_nxt = IDLE;
        else if (start_tick) state_nxt = ARM;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      delay_ms  <= '0;
      delay_cnt <= '0;
      result    <= '0;
      best      <= EARLY_BCD;
    end else begin
      state <= state_nxt;
      if (state == ARM) begin
        delay_ms  <= delay_ms_of(rnd);
        delay_cnt <= '0;
      end else if (state == WAIT && tick) begin
        delay_cnt <= delay_cnt + 14'd1;
      end
      // Stop and timeout both latch the live counter; it already reads 1000 on timeout.
      if (state == TIME && state_nxt == DONE) begin
        result <= cnt.cnt_d;
        if (cnt.cnt_d < best) best <= cnt.cnt_d;
      end
    end
  end

  always_comb begin
    hex         = BLANK_HEX;
    dp          = '1;
    led         = 1'b0;
    cnt.cnt_clr = 1'b0;
    cnt.cnt_inc = 1'b0;
    unique case (state)
      IDLE:  hex = IDLE_HEX;
      ARM:   cnt.cnt_clr = 1'b1;
      WAIT:  ;
      TIME: begin
        led         = 1'b1;
        hex         = cnt.cnt_d;
        cnt.cnt_inc = tick && !stop_tick;
      end
      DONE: begin
        hex = result;
        dp  = 4'b0111;
      end
      EARLY: hex = EARLY_BCD;
      default: ;
    endcase
  end

endmodule

// File: doc/reaction_ctrl.md
# reaction_ctrl

Sequencing controller for the reaction-timer game. Consumes debounced button ticks and a 4-bit LFSR value, drives the external 4-digit BCD ms counter (`bcd_counter`) through clear/increment strobes, generates the random pre-start delay, and selects what the 4-digit hex display shows. Holds the last result and the session best time. Sits between the debouncers/LFSR and `disp_hex_mux`.

## Interface
- `CLK_HZ`, default 100_000_000: clock frequency. `TICK_DIV = CLK_HZ/1000` clocks per ms; must be ≥ 2.
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start_tick`  in  1  one-cycle debounced start press
- `stop_tick`  in  1  one-cycle debounced stop press
- `clear_tick`  in  1  one-cycle debounced clear press
- `rnd`  in  4  LFSR value, sampled in ARM only
- `cnt_d`  in  16  BCD digits from the counter: d3 is [15:12], d0 is [3:0]
- `cnt_clr`  out  1  synchronous clear strobe to the counter
- `cnt_inc`  out  1  one-cycle increment strobe to the counter, one per ms
- `hex`  out  16  display nibbles: hex3 is [15:12]
- `dp`  out  4  decimal points, active-low
- `led`  out  1  "press now" lamp
- `best`  out  16  best BCD time this session

## Operation
- States: IDLE, ARM, WAIT, TIME, DONE, EARLY.
- Input priority in every state: clear_tick, then stop_tick, then start_tick.
- **IDLE**
  - hex = {BLANK, BLANK, H, I}; led = 0.
  - start_tick → ARM.
- **ARM** (exactly 1 cycle)
  - cnt_clr = 1.
  - delay_ms = max(rnd, 2) × 1000, in 14 bits (range 2000–15000).
  - delay_cnt = 0; ms prescaler reset.
  - Next state: WAIT.
- **WAIT**
  - hex all BLANK; led = 0.
  - delay_cnt increments on each ms tick.
  - stop_tick → EARLY.
  - When delay_cnt == delay_ms → TIME. The prescaler is reset on this entry.
- **TIME**
  - led = 1; hex = cnt_d (live); cnt_inc = ms tick.
  - stop_tick → DONE. cnt_inc is suppressed in that cycle and result = cnt_d is latched.
  - cnt_d == 16'h1000 (timeout) → DONE with result 1000.
- **DONE**
  - hex = result; dp = 4'b0111 (point after d3, meaning seconds).
  - led = 0.
  - On entry: if result < best (BCD magnitude compare), then best = result.
  - start_tick → ARM.
- **EARLY**
  - hex = 9999; led = 0.
  - start_tick → ARM.
- clear_tick in any state other than IDLE → IDLE. best is kept.
- dp = 4'b1111 in every state except DONE.
- The outputs hex, dp, led, cnt_clr and cnt_inc are decoded from the registered state and registers only. None depends combinationally on the tick inputs, with one exception: cnt_inc is gated by stop_tick.

## Timing
- Reset values:
  - state = IDLE; hex = {C, C, A, B}; dp = 4'hF; led = 0.
  - cnt_clr = 0; cnt_inc = 0; best = 16'h9999.
  - result = 0; delay_cnt = 0; prescaler = 0.
- An asserted rst mid-game forces IDLE immediately. best returns to 9999.
- ms tick: one cycle every TICK_DIV clocks, counted from the prescaler reset.
- Delay latency: TIME is entered exactly delay_ms × TICK_DIV clocks after leaving ARM, ±1 cycle.
- Reaction measurement:
  - The first cnt_inc comes TICK_DIV clocks after TIME entry.
  - The counter updates the cycle after cnt_inc.
- Stop and ms tick in the same TIME cycle: stop wins, no increment, and the pre-increment value is latched.
- Stop and timeout in the same cycle: stop path; the latched value is 1000.
- start_tick in WAIT or TIME is ignored.
- stop_tick in IDLE, DONE or EARLY is ignored.

## Structure
- Package `reaction_pkg` holds:
  - the state enum `rc_state_t`;
  - the glyph constants `GLYPH_BLANK = 4'hC`, `GLYPH_H = 4'hA`, `GLYPH_I = 4'hB`;
  - `TIMEOUT_BCD = 16'h1000`, `EARLY_BCD = 16'h9999`, `MIN_DELAY_S = 2`.
- Sub-module `ms_tick`:
  - parameter DIV; inputs clk, rst, sync_clr; output tick;
  - implemented as a prescaler counter.
- Everything else (state register, delay counter, result/best registers, display decode) lives in `reaction_ctrl`.

## Test plan
All benches use CLK_HZ = 10_000, so TICK_DIV = 10. A behavioral BCD counter model is connected.
- **Reset:** rst pulse → hex = CCAB, led = 0, best = 9999, cnt_inc never asserted.
- **Normal run:**
  - Stimulus: start with rnd = 3; stop 2345 clocks after led rises.
  - Required: led rises 30000 ± 1 clocks after ARM; DONE shows 0234; dp = 0111; best = 0234.
- **Clamp and early stop:**
  - Stimulus: rnd = 0 (delay 2000 ms); stop at 5000 clocks.
  - Required: EARLY, hex = 9999, best unchanged; start re-enters ARM.
- **Timeout:**
  - Stimulus: no stop in TIME.
  - Required: DONE at cnt_d = 1000, hex = 1000.
  - Then: a second run with result 0150 sets best = 0150; a third run with 0400 leaves best = 0150.
- **Simultaneous events:**
  - stop on the same cycle as the ms tick → no cnt_inc; latched value equals cnt_d.
  - clear and stop on the same cycle in TIME → IDLE.
- **Reset mid-TIME:** rst asserted → IDLE at once; led = 0 asynchronously; best = 9999.
